// File: rtl/taiga_axi_master_pkg.sv
// Shared types for the Taiga AXI4 master: FSM state, AXI encodings and
// err_sticky bit positions.
package taiga_axi_types;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR_RD = 2'd1,
    ST_ADDR_WR = 2'd2,
    ST_DATA_WR = 2'd3
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int ERR_BAD_RESP = 0;
  localparam int ERR_4K_CROSS = 1;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_outstanding_counter.sv
// Per-direction count of issued-but-unfinished AXI transactions.
module axi_outstanding_counter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic avail_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Simultaneous issue and retire leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i)      count_d = count_q + CNT_W'(1);
    else if (!inc_i && dec_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign avail_o = count_q < CNT_W'(MAX_OUTSTANDING);
  assign busy_o  = count_q != '0;

endmodule

// File: rtl/taiga_axi_master.sv
// Simple request-driven AXI4 master: one address phase per request, write data
// and read data pass through combinationally, responses retire outstanding slots.
module taiga_axi_master
  import taiga_axi_types::*;
#(
  parameter int          ADDR_W          = 32,
  parameter int          DATA_W          = 32,
  parameter int          ID_W            = 6,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          MAX_BURST       = 16,
  parameter logic [3:0]  CACHE           = 4'b0011,
  localparam int         LEN_W           = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                clk,
  input  logic                rst,
  // Request side
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rnw,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_be,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                rd_err,
  output logic                wr_done,
  output logic                wr_err,
  output logic [1:0]          err_sticky,
  input  logic                err_clear,
  output logic [1:0]          dbg_state_o,
  // AXI read address / data
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arqos,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  // AXI write address / data / response
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);

  // Every channel uses valid/ready: a transfer happens on a clock edge where
  // both are high, and a raised valid holds its payload until that edge.

  localparam int SIZE_LOG = $clog2(DATA_W / 8);

  state_e              state_q;
  logic                arvalid_q, awvalid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q, beat_q;
  logic [ID_W-1:0]     rid_q, wid_q;
  logic                wr_done_q, wr_err_q;
  logic [1:0]          err_q, err_d, err_set;
  logic                rd_avail, wr_avail, rd_busy, wr_busy;
  logic                req_hs, ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic                in_data_wr;
  logic [13:0]         burst_bytes, last_byte;
  logic                cross_4k;
  logic                unused_ids;

  assign in_data_wr = state_q == ST_DATA_WR;
  assign req_ready  = (state_q == ST_IDLE) && (req_rnw ? rd_avail : wr_avail);

  assign req_hs = req_valid && req_ready;
  assign ar_hs  = arvalid_q && m_axi_arready;
  assign aw_hs  = awvalid_q && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign r_hs   = m_axi_rvalid && m_axi_rready;
  assign b_hs   = m_axi_bvalid && m_axi_bready;

  // Offset of the burst's last byte within the current 4 KB page.
  assign burst_bytes = (14'(req_len) + 14'd1) << SIZE_LOG;
  assign last_byte   = {2'b00, req_addr[11:0]} + burst_bytes - 14'd1;
  assign cross_4k    = last_byte[13:12] != 2'b00;

  always_comb begin
    err_set               = 2'b00;
    err_set[ERR_BAD_RESP] = (r_hs && resp_is_err(m_axi_rresp)) ||
                            (b_hs && resp_is_err(m_axi_bresp));
    err_set[ERR_4K_CROSS] = req_hs && cross_4k;
    err_d                 = (err_clear ? 2'b00 : err_q) | err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      rid_q     <= '0;
      wid_q     <= '0;
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      wr_done_q <= b_hs;
      wr_err_q  <= b_hs && resp_is_err(m_axi_bresp);
      err_q     <= err_d;
      case (state_q)
        ST_IDLE: if (req_hs) begin
          addr_q <= req_addr;
          len_q  <= req_len;
          if (req_rnw) begin
            state_q   <= ST_ADDR_RD;
            arvalid_q <= 1'b1;
          end else begin
            state_q   <= ST_ADDR_WR;
            awvalid_q <= 1'b1;
          end
        end
        ST_ADDR_RD: if (ar_hs) begin
          arvalid_q <= 1'b0;
          rid_q     <= rid_q + ID_W'(1);
          state_q   <= ST_IDLE;
        end
        ST_ADDR_WR: if (aw_hs) begin
          awvalid_q <= 1'b0;
          wid_q     <= wid_q + ID_W'(1);
          beat_q    <= '0;
          state_q   <= ST_DATA_WR;
        end
        ST_DATA_WR: if (w_hs) begin
          if (m_axi_wlast) state_q <= ST_IDLE;
          else             beat_q  <= beat_q + LEN_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  axi_outstanding_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_rd_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (ar_hs),
    .dec_i   (r_hs && m_axi_rlast),
    .avail_o (rd_avail),
    .busy_o  (rd_busy)
  );

  axi_outstanding_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_wr_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (aw_hs),
    .dec_i   (b_hs),
    .avail_o (wr_avail),
    .busy_o  (wr_busy)
  );

  assign m_axi_arid    = rid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(len_q);
  assign m_axi_arsize  = 3'(SIZE_LOG);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arcache = CACHE;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arqos   = 4'h0;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_awid    = wid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'(len_q);
  assign m_axi_awsize  = 3'(SIZE_LOG);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awcache = CACHE;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awqos   = 4'h0;
  assign m_axi_awvalid = awvalid_q;

  // Write data is only forwarded while a burst is open.
  assign m_axi_wvalid = wd_valid && in_data_wr;
  assign wd_ready     = m_axi_wready && in_data_wr;
  assign m_axi_wdata  = wd_data;
  assign m_axi_wstrb  = wd_be;
  assign m_axi_wlast  = in_data_wr && (beat_q == len_q);

  assign rd_valid     = m_axi_rvalid;
  assign m_axi_rready = rd_ready;
  assign rd_data      = m_axi_rdata;
  assign rd_last      = m_axi_rlast;
  assign rd_err       = resp_is_err(m_axi_rresp);

  assign m_axi_bready = wr_busy;
  assign wr_done      = wr_done_q;
  assign wr_err       = wr_err_q;
  assign err_sticky   = err_q;
  assign dbg_state_o  = state_q;

  // Responses are retired in order, so returned IDs are not needed.
  assign unused_ids = ^{m_axi_rid, m_axi_bid, rd_busy};

endmodule

// File: tb/tb_taiga_axi_master.sv
// Directed-plus-random bench for taiga_axi_master with a small AXI slave driver
// and a behavioural model of IDs, 4 KB crossings and sticky errors.
module tb_taiga_axi_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 6;
  localparam int LEN_W  = 4;

  logic              clk, rst;
  logic              req_valid, req_ready, req_rnw;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wd_valid, wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic [3:0]        wd_be;
  logic              rd_valid, rd_ready, rd_last, rd_err;
  logic [DATA_W-1:0] rd_data;
  logic              wr_done, wr_err, err_clear;
  logic [1:0]        err_sticky, dbg_state;
  logic [ID_W-1:0]   arid, awid, rid, bid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [7:0]        arlen, awlen;
  logic [2:0]        arsize, awsize, arprot, awprot;
  logic [1:0]        arburst, awburst, rresp, bresp;
  logic [3:0]        arcache, awcache, arqos, awqos;
  logic              arlock, awlock, arvalid, arready, awvalid, awready;
  logic [DATA_W-1:0] rdata, wdata;
  logic [3:0]        wstrb;
  logic              rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;

  taiga_axi_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                     .MAX_OUTSTANDING(4), .MAX_BURST(16), .CACHE(4'b0011)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_be(wd_be),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .rd_err(rd_err),
    .wr_done(wr_done), .wr_err(wr_err), .err_sticky(err_sticky),
    .err_clear(err_clear), .dbg_state_o(dbg_state),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arlock(arlock), .m_axi_arqos(arqos),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awlock(awlock), .m_axi_awqos(awqos),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference model state
  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                pend_len_q[$];
  int                rd_hs_cnt, wr_hs_cnt;
  logic [1:0]        exp_sticky;
  logic [31:0]       cur_addr;
  int                cur_len;
  int                last_held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit crosses_4k(input logic [31:0] addr, input int len);
    return (int'(addr[11:0]) + (len + 1) * (DATA_W / 8)) > 4096;
  endfunction

  // Driver tasks
  task automatic issue_req(input bit rnw, input logic [31:0] addr, input int len);
    int waited = 0;
    req_rnw = rnw; req_addr = addr; req_len = 4'(len); req_valid = 1'b1;
    cur_addr = addr; cur_len = len;
    #1;
    while (!req_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    if (crosses_4k(addr, len)) exp_sticky[1] = 1'b1;
    check("err_sticky_after_req", err_sticky, exp_sticky);
  endtask

  task automatic addr_phase(input bit rnw, input int adly);
    last_held = 0;
    for (int c = 0; c <= adly; c++) begin
      if (rnw) begin
        check("araddr", araddr, cur_addr);
        check("arlen", arlen, cur_len);
        check("arid", arid, rd_hs_cnt % 64);
        if (arvalid) last_held++;
        arready = (c == adly);
      end else begin
        check("awaddr", awaddr, cur_addr);
        check("awlen", awlen, cur_len);
        check("awid", awid, wr_hs_cnt % 64);
        if (awvalid) last_held++;
        awready = (c == adly);
      end
      tick();
    end
    arready = 1'b0; awready = 1'b0;
    if (rnw) rd_hs_cnt++; else wr_hs_cnt++;
    check("addr_valid_held", last_held, adly + 1);
    check("addr_valid_drop", rnw ? arvalid : awvalid, 0);
  endtask

  task automatic r_phase(input int len, input logic [1:0] last_resp);
    for (int b = 0; b <= len; b++) begin
      exp_q.push_back($urandom);
      rvalid = 1'b1; rdata = exp_q[$]; rlast = (b == len);
      rresp = (b == len) ? last_resp : 2'b00;
      #1;
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, exp_q.pop_front());
      check("rd_last", rd_last, b == len);
      check("rd_err", rd_err, (b == len) && (last_resp != 2'b00));
      check("rready", rready, 1);
      if ((b == len) && (last_resp != 2'b00)) exp_sticky[0] = 1'b1;
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    check("err_sticky_after_r", err_sticky, exp_sticky);
  endtask

  task automatic w_phase(input int len, input bit gap);
    logic [31:0] d;
    logic [3:0]  be;
    for (int b = 0; b <= len; b++) begin
      if (gap) begin
        wd_valid = 1'b0;
        #1 check("w_gap", wvalid, 0);
        tick();
      end
      d = $urandom; be = 4'($urandom_range(1, 15));
      wd_valid = 1'b1; wd_data = d; wd_be = be; wready = 1'b1;
      #1;
      check("wvalid", wvalid, 1);
      check("wdata", wdata, d);
      check("wstrb", wstrb, be);
      check("wlast", wlast, b == len);
      check("wd_ready", wd_ready, 1);
      tick();
    end
    #1;
    check("w_after_last", wvalid, 0);
    check("wd_ready_after_last", wd_ready, 0);
    wd_valid = 1'b0; wready = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] resp, input bit clr);
    check("bready", bready, 1);
    bvalid = 1'b1; bresp = resp; err_clear = clr;
    #1 check("wr_done_early", wr_done, 0);
    tick();
    bvalid = 1'b0; err_clear = 1'b0;
    exp_sticky = (clr ? 2'b00 : exp_sticky) | {1'b0, resp != 2'b00};
    check("wr_done", wr_done, 1);
    check("wr_err", wr_err, resp != 2'b00);
    check("err_sticky_after_b", err_sticky, exp_sticky);
    tick();
    check("wr_done_pulse", wr_done, 0);
    check("bready_idle", bready, 0);
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    exp_sticky = 2'b00;
    check("err_clear", err_sticky, 0);
  endtask

  task automatic write_txn(input logic [31:0] addr, input int len, input int adly,
                           input bit gap, input logic [1:0] resp, input bit clr);
    issue_req(1'b0, addr, len);
    addr_phase(1'b0, adly);
    w_phase(len, gap);
    b_phase(resp, clr);
  endtask

  initial begin
    logic [31:0] r;
    int          l;
    rst = 1'b1; req_valid = 0; req_rnw = 0; req_addr = '0; req_len = '0;
    wd_valid = 0; wd_data = '0; wd_be = '0; rd_ready = 1'b1; err_clear = 0;
    arready = 0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = '0; bresp = 2'b00; bvalid = 0;
    rd_hs_cnt = 0; wr_hs_cnt = 0; exp_sticky = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();

    // Read, len 3 at 0x1000 with arready delayed two cycles
    issue_req(1'b1, 32'h0000_1000, 3);
    check("arsize", arsize, 2);
    check("arburst", arburst, 1);
    check("arcache", arcache, 4'b0011);
    addr_phase(1'b1, 2);
    r_phase(3, 2'b00);

    // Write, len 1 with gapped write data
    r = $urandom;
    write_txn({r[31:12], 12'h100}, 1, $urandom_range(0, 2), 1'b1, 2'b00, 1'b0);

    // Four reads without returns fill the read slots
    for (int i = 0; i < 4; i++) begin
      r = $urandom; l = $urandom_range(0, 3);
      issue_req(1'b1, {r[31:12], 12'h0}, l);
      addr_phase(1'b1, $urandom_range(0, 1));
      pend_len_q.push_back(l);
    end
    req_rnw = 1'b1;
    #1 check("req_ready_rd_full", req_ready, 0);
    req_rnw = 1'b0;
    #1 check("req_ready_wr_free", req_ready, 1);
    r_phase(pend_len_q.pop_front(), 2'b00);
    req_rnw = 1'b1;
    #1 check("req_ready_reenabled", req_ready, 1);
    r = $urandom; l = $urandom_range(0, 3);
    issue_req(1'b1, {r[31:12], 12'h0}, l);
    addr_phase(1'b1, 0);
    pend_len_q.push_back(l);
    while (pend_len_q.size() > 1) r_phase(pend_len_q.pop_front(), 2'b00);
    r_phase(pend_len_q.pop_front(), 2'b11);
    clear_err();

    // Write error response, then error coinciding with clear
    write_txn(32'h0000_2000, 0, 0, 1'b0, 2'b10, 1'b0);
    repeat (3) tick();
    check("err_sticky_holds", err_sticky, exp_sticky);
    clear_err();
    write_txn(32'h0000_3000, 1, 1, 1'b0, 2'b10, 1'b1);
    check("err_set_beats_clear", err_sticky[0], 1);
    clear_err();

    // 65 random writes after reset: awid runs 0..63 then wraps to 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_hs_cnt = 0; wr_hs_cnt = 0; exp_sticky = 2'b00;
    tick();
    for (int i = 0; i < 65; i++) begin
      r = $urandom;
      r[1:0] = 2'b00;
      write_txn(r, $urandom_range(0, 3), $urandom_range(0, 1),
                1'($urandom_range(0, 1)), 2'b00, 1'b0);
    end
    check("awid_wrapped", awid, 1);
    clear_err();

    // 4 KB crossing is flagged but issued unchanged; reset lands mid-burst
    issue_req(1'b0, 32'h0000_0FFC, 1);
    check("err_4k", err_sticky[1], 1);
    addr_phase(1'b0, 0);
    wd_valid = 1'b1; wd_data = $urandom; wd_be = 4'hF; wready = 1'b1;
    tick();
    check("mid_burst_wvalid", wvalid, 1);
    check("mid_burst_bready", bready, 1);
    rst = 1'b1;
    #1;
    check("async_rst_wvalid", wvalid, 0);
    check("async_rst_awvalid", awvalid, 0);
    check("async_rst_arvalid", arvalid, 0);
    check("async_rst_bready", bready, 0);
    check("async_rst_wr_done", wr_done, 0);
    check("async_rst_err_sticky", err_sticky, 0);
    check("async_rst_state", dbg_state, 0);
    wd_valid = 1'b0; wready = 1'b0;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Time limit so the bench always ends on its own
  initial begin
    #500000;
    $display("FAIL timeout: observed no end of stimulus, expected completion");
    $fatal(1, "timeout");
  end

endmodule
